// File: rtl/demultiplexer.sv
// One-input, CHANNELS-output demultiplexer with a one-word holding register
// per channel and valid/ready handshakes on every side.
//
// Parameters:
//   WIDTH      data width of each channel
//   CHANNELS   number of output channels (>= 2); SELW = $clog2(CHANNELS)
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_data    input word
//   in_sel     destination channel index
//   in_valid   in_data / in_sel valid
//   in_ready   input accepted this cycle
//   out_bus    packed channel data, channel c at
//              [(CHANNELS-1-c)*WIDTH +: WIDTH]
//   out_valid  per-channel word held
//   out_ready  per-channel consumer takes the word
//   drop_count saturating count of discarded out-of-range words
// Build option:
//   DEMUX_DROP_COUNT_EN  when defined, drop_count counts discarded words;
//                        otherwise it is tied to 0 and no counter is built.
module demultiplexer #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 2,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SELW-1:0]           in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_bus,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [7:0]                drop_count
);

    logic [WIDTH-1:0]    data_q [CHANNELS];
    logic [CHANNELS-1:0] vld_q;
    logic [CHANNELS-1:0] fill;
    logic [CHANNELS-1:0] drain;

    // An out-of-range select matches no channel, so in_ready keeps its
    // default of 1 and the word is swallowed without touching any channel.
    always_comb begin
        in_ready = 1'b1;
        fill     = '0;
        drain    = vld_q & out_ready;
        for (int c = 0; c < CHANNELS; c++) begin
            if (in_sel == SELW'(c)) begin
                in_ready = !vld_q[c] || out_ready[c];
                fill[c]  = in_valid && (!vld_q[c] || out_ready[c]);
            end
        end
    end

    // Fill has priority over drain so a simultaneous drain+fill keeps
    // valid high and sustains one word per cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                data_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (fill[c]) begin
                    data_q[c] <= in_data;
                    vld_q[c]  <= 1'b1;
                end else if (drain[c]) begin
                    vld_q[c]  <= 1'b0;
                end
            end
        end
    end

    assign out_valid = vld_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_pack
        assign out_bus[(CHANNELS-1-c)*WIDTH +: WIDTH] = data_q[c];
    end

`ifdef DEMUX_DROP_COUNT_EN
    localparam logic [SELW:0] NCH = (SELW+1)'(CHANNELS);

    logic       in_range;
    logic [7:0] drop_q;

    assign in_range = {1'b0, in_sel} < NCH;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= 8'd0;
        end else if (in_valid && !in_range && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_demultiplexer.sv
// Scoreboard bench for demultiplexer: directed handshake scenarios, random
// traffic on a 2-channel instance, and out-of-range drops on a 3-channel one.
module tb_demultiplexer;

    logic        clock;
    logic        reset_n;
    logic [31:0] in_data;
    logic [0:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_bus;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [7:0]  drop_count;

    logic [7:0]  i3_data;
    logic [1:0]  i3_sel;
    logic        i3_valid;
    logic        i3_ready;
    logic [23:0] o3_bus;
    logic [2:0]  o3_valid;
    logic [7:0]  d3_count;

    int total = 0;
    int bad   = 0;
    bit mon_en = 0;

    // Each channel holds at most one word, so the model is just a
    // per-channel queue of words accepted but not yet consumed.
    logic [31:0] sbq [2][$];

    demultiplexer #(.WIDTH(32), .CHANNELS(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_bus(out_bus), .out_valid(out_valid),
        .out_ready(out_ready), .drop_count(drop_count)
    );

    demultiplexer #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clock(clock), .reset_n(reset_n),
        .in_data(i3_data), .in_sel(i3_sel),
        .in_valid(i3_valid), .in_ready(i3_ready),
        .out_bus(o3_bus), .out_valid(o3_valid),
        .out_ready(3'b111), .drop_count(d3_count)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] chan(input logic [63:0] b, input int c);
        return b[(1-c)*32 +: 32];
    endfunction

    // Monitor: just before each rising edge, compare presented outputs with
    // the scoreboard and retire words the consumer takes at that edge.
    always begin
        @(negedge clock);
        #4;
        if (mon_en) begin
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("out_valid[%0d]", c), 64'(out_valid[c]),
                    64'(sbq[c].size() > 0));
                if (out_valid[c] && sbq[c].size() > 0) begin
                    chk($sformatf("data[%0d]", c), 64'(chan(out_bus, c)),
                        64'(sbq[c][0]));
                    if (out_ready[c]) void'(sbq[c].pop_front());
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [0:0] s,
                       input logic [31:0] d, input logic [1:0] r);
        logic exp_rdy;
        @(negedge clock);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #3;
        exp_rdy = (sbq[s].size() == 0) || r[s];
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clock);
        #1;
        if (v && exp_rdy) sbq[s].push_back(d);
    endtask

    initial begin
        reset_n   = 0;
        in_valid  = 0;
        in_sel    = 0;
        in_data   = 0;
        out_ready = 2'b11;
        i3_valid  = 0;
        i3_sel    = 0;
        i3_data   = 0;
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_bus", out_bus, 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        @(negedge clock);
        reset_n = 1;
        mon_en  = 1;

        // Single word to channel 1, visible one cycle, then gone.
        cyc(1, 1, 32'hA5A5A5A5, 2'b11);
        cyc(0, 0, 32'h0, 2'b11);
        cyc(0, 0, 32'h0, 2'b11);

        // Stall on channel 0, then drain and refill at the same edge.
        cyc(1, 0, 32'h11, 2'b00);
        cyc(1, 0, 32'h22, 2'b00);
        cyc(1, 0, 32'h22, 2'b01);
        cyc(0, 0, 32'h0, 2'b01);

        // Stalled channel 0 must not block channel 1.
        cyc(1, 0, 32'h44, 2'b00);
        cyc(1, 1, 32'h33, 2'b00);
        cyc(0, 0, 32'h0, 2'b00);

        // Reset pulse between edges with both channels full and stalled.
        @(negedge clock);
        mon_en = 0;
        #1;
        reset_n = 0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_bus", out_bus, 64'd0);
        reset_n = 1;
        sbq[0].delete();
        sbq[1].delete();
        @(posedge clock);
        #1;
        mon_en = 1;
        cyc(1, 0, 32'h55, 2'b00);
        cyc(1, 1, 32'h66, 2'b00);
        cyc(0, 0, 32'h0, 2'b11);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom, 2'($urandom_range(0, 3)));
        end
        cyc(0, 0, 32'h0, 2'b11);
        cyc(0, 0, 32'h0, 2'b11);
        chk("drained", 64'(sbq[0].size() + sbq[1].size()), 64'd0);
        chk("drop_2ch", 64'(drop_count), 64'd0);

        // Out-of-range select on the 3-channel instance.
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            i3_valid = 1;
            i3_sel   = 2'd3;
            i3_data  = 8'($urandom);
            #3;
            chk("oor_ready", 64'(i3_ready), 64'd1);
            chk("oor_valid", 64'(o3_valid), 64'd0);
        end
        @(negedge clock);
        i3_valid = 0;
        #3;
`ifdef DEMUX_DROP_COUNT_EN
        chk("drop_3ch", 64'(d3_count), 64'd255);
`else
        chk("drop_3ch", 64'(d3_count), 64'd0);
`endif
        chk("oor_bus", 64'(o3_bus), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
